msg_scroll: RTL and testbench

Scroll sequencer that sits directly upstream of the message ROM in the advertisement display path. It periodically walks a window of DIGITS consecutive message addresses, reads the 5-bit character codes back from the ROM, and presents them as one frame to the display driver. After each frame it advances the window start by one position, so the message scrolls with wrap-around.

---
 rtl/msg_scroll.sv | 114 +++++++++++
 tb/tb_msg_scroll.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/msg_scroll.sv
// msg_scroll: scroll sequencer for the message ROM. Every DIV enabled clocks
// it reads DIGITS consecutive message addresses (wrapping within 1..MSG_LEN)
// and presents them as one frame, then advances the window start by one.
module msg_scroll #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIV     = 25_000_000,
    parameter int unsigned MSG_LEN = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [3:0]            rom_addr,
    input  logic [4:0]            rom_data,
    output logic [5*DIGITS-1:0]   chars,
    output logic                  frame_valid,
    output logic                  busy
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [4:0] Space = 5'd27;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     pending_q, pending_d;
    logic [3:0]               base_q, base_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [DIGITS-1:0][4:0]   shadow_q, shadow_d;
    logic [5*DIGITS-1:0]      chars_q, chars_d;
    logic                     fv_q, fv_d;

    logic                     tick;
    logic [4:0]               addr_sum;
    logic [4:0]               addr_wrap;

    assign tick = en && (presc_q == PW'(DIV - 1));

    // Window address; 5-bit sum so base+idx cannot overflow before the wrap.
    assign addr_sum  = {1'b0, base_q} + 5'(idx_q);
    assign addr_wrap = (addr_sum > 5'(MSG_LEN)) ? (addr_sum - 5'(MSG_LEN)) : addr_sum;

    // Prescaler: free-runs 0..DIV-1 while enabled, holds otherwise.
    always_comb begin
        presc_d = presc_q;
        if (en) begin
            presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + 1'b1;
        end
    end

    // Fetch FSM next-state and outputs.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        base_d    = base_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        chars_d   = chars_q;
        fv_d      = 1'b0;
        busy      = 1'b0;
        rom_addr  = 4'd0;
        unique case (state_q)
            StIdle: begin
                if (en && (tick || pending_q)) begin
                    state_d   = StFetch;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            StFetch: begin
                busy             = 1'b1;
                rom_addr         = addr_wrap[3:0];
                shadow_d[idx_q]  = rom_data;
                idx_d            = idx_q + 1'b1;
                if (idx_q == IW'(DIGITS - 1)) begin
                    // Publish including the sample captured on this edge.
                    chars_d = shadow_d;
                    fv_d    = 1'b1;
                    base_d  = (base_q == 4'(MSG_LEN)) ? 4'd1 : base_q + 4'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            pending_q <= 1'b1;
            base_q    <= 4'd1;
            idx_q     <= '0;
            shadow_q  <= {DIGITS{Space}};
            chars_q   <= {DIGITS{Space}};
            fv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            chars_q   <= chars_d;
            fv_q      <= fv_d;
        end
    end

    assign chars       = chars_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_msg_scroll.sv
// Bench for msg_scroll: ROM model, scoreboard of expected frames checked on
// every frame_valid pulse, plus per-scenario inline checks.
module tb_msg_scroll;

    localparam int DIGITS  = 4;
    localparam int DIV     = 8;
    localparam int MSG_LEN = 15;
    localparam int CW      = 5 * DIGITS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [3:0]    rom_addr;
    logic [4:0]    rom_data;
    logic [CW-1:0] chars;
    logic          frame_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_fv = 0;

    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] shown_chars;
    logic [CW-1:0] all_space;

    msg_scroll #(.DIGITS(DIGITS), .DIV(DIV), .MSG_LEN(MSG_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .chars       (chars),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] rom_f(input logic [3:0] a);
        case (a)
            4'd1:  return 5'd19;
            4'd2:  return 5'd24;
            4'd3:  return 5'd11;
            4'd4:  return 5'd19;
            4'd5:  return 5'd1;
            4'd6:  return 5'd20;
            4'd7:  return 5'd1;
            4'd8:  return 5'd14;
            4'd9:  return 5'd12;
            4'd10: return 5'd27;
            4'd11: return 5'd2;
            4'd12: return 5'd0;
            4'd13: return 5'd2;
            4'd14: return 5'd5;
            4'd15: return 5'd27;
            default: return 5'd27;
        endcase
    endfunction

    always_comb rom_data = rom_f(rom_addr);

    function automatic int addr_of(input int base, input int k);
        return ((base - 1 + k) % MSG_LEN) + 1;
    endfunction

    // Scoreboard: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            logic [CW-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame chars=%h (no frame expected)", chars);
            end else begin
                e = exp_q.pop_front();
                if (chars !== e) begin
                    errors++;
                    $display("FAIL frame_chars got=%h exp=%h", chars, e);
                end
                shown_chars = e;
            end
        end
    end

    // One frame fetch: addresses, busy, stable chars, pulse and period.
    task automatic run_frame(input int base, input int gap, input bit drop_en);
        logic [CW-1:0] e;
        int waited;
        for (int k = 0; k < DIGITS; k++) e[5*k +: 5] = rom_f(4'(addr_of(base, k)));
        exp_q.push_back(e);
        waited = 0;
        while (busy !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (busy !== 1'b1) begin
            checks++; errors++;
            $display("FAIL fetch_start_timeout base=%0d busy=%b exp=1", base, busy);
            void'(exp_q.pop_back());
            return;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy !== 1'b1 || rom_addr !== 4'(addr_of(base, k))) begin
                errors++;
                $display("FAIL fetch_addr base=%0d k=%0d got addr=%0d busy=%b exp addr=%0d busy=1",
                         base, k, rom_addr, busy, addr_of(base, k));
            end
            checks++;
            if (chars !== shown_chars || frame_valid !== 1'b0) begin
                errors++;
                $display("FAIL chars_stable base=%0d got=%h fv=%b exp=%h fv=0",
                         base, chars, frame_valid, shown_chars);
            end
            if (k == 0 && drop_en) en = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_pulse base=%0d got fv=%b busy=%b exp fv=1 busy=0",
                     base, frame_valid, busy);
        end
        if (drop_en) en = 1'b1;
        if (gap != 0) begin
            checks++;
            if (cyc - last_fv != gap) begin
                errors++;
                $display("FAIL frame_period base=%0d got=%0d exp=%0d", base, cyc - last_fv, gap);
            end
        end
        last_fv = cyc;
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (chars !== all_space || frame_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL %s got chars=%h fv=%b busy=%b addr=%0d exp chars=%h fv=0 busy=0 addr=0",
                     tag, chars, frame_valid, busy, rom_addr, all_space);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        shown_chars = all_space;
        repeat (3) @(negedge clk);
        check_reset_state("reset_state");
    endtask

    task automatic test_first_frame();
        en  = 1'b1;
        rst = 1'b0;
        run_frame(1, 0, 1'b0);
    endtask

    task automatic test_scroll_wrap();
        run_frame(2, 0, 1'b0);
        for (int b = 3; b <= MSG_LEN; b++) run_frame(b, DIV, 1'b0);
        run_frame(1, DIV, 1'b0);
    endtask

    task automatic test_en_pause();
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (frame_valid !== 1'b0 || busy !== 1'b0 || chars !== shown_chars) begin
                errors++;
                $display("FAIL pause_idle got fv=%b busy=%b chars=%h exp fv=0 busy=0 chars=%h",
                         frame_valid, busy, chars, shown_chars);
            end
        end
        en = 1'b1;
        run_frame(2, DIV + 20, 1'b0);
    endtask

    task automatic test_en_drop_fetch();
        run_frame(3, DIV, 1'b1);
    endtask

    task automatic test_reset_mid_fetch();
        int waited = 0;
        while (busy !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("reset_mid_fetch");
        shown_chars = all_space;
        repeat (3) begin
            @(negedge clk);
            check_reset_state("reset_hold");
        end
        rst = 1'b0;
        run_frame(1, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frames_outstanding got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        all_space   = {DIGITS{5'd27}};
        shown_chars = all_space;
        test_reset();
        test_first_frame();
        test_scroll_wrap();
        test_en_pause();
        test_en_drop_fetch();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
